sw_debounce: RTL and testbench
==============================

# sw_debounce

Per-bit synchronizer and debouncer for the Arty slide switches. It sits between the raw `sw` pads and the switch-processing chain (the +1 adder feeding the LED blinker). It converts asynchronous, bouncing switch levels into clean, `clk`-synchronous levels, and also produces one-cycle edge pulses. Each bit is processed independently.

## Interface
Parameters:
- `WIDTH`, default 4: number of switch bits.
- `STABLE_CYCLES`, default 1000000: number of consecutive `clk` cycles an input must hold a new level before it is accepted. This is 10 ms at 100 MHz. Legal range is 1 to 2^24-1.
- Counter width is a derived localparam, `$clog2(STABLE_CYCLES+1)`. It is not user-settable.

Ports:
- `clk` input 1: system clock; all state is on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `sw_in` input WIDTH: raw switch levels, asynchronous to `clk`.
- `sw_out` output WIDTH: debounced, synchronous switch levels.
- `sw_rise` output WIDTH: one-cycle pulse per bit when `sw_out[i]` goes 0→1.
- `sw_fall` output WIDTH: one-cycle pulse per bit when `sw_out[i]` goes 1→0.
- `changed` output 1: OR-reduction of (`sw_rise` | `sw_fall`), registered in the same cycle as the pulses.

## Operation
- Synchronizer:
  - Each bit passes through two flops, `s1[i]` then `s2[i]`.
  - Only `s2` is used downstream.
- Per-bit FSM with two states:
  - STABLE: `cnt[i]` = 0, `s2[i]` == `sw_out[i]`.
  - PENDING: `s2[i]` != `sw_out[i]`, counting.
- On each edge, evaluated on pre-edge values:
  - If `s2[i]` == `sw_out[i]`: `cnt[i]` ← 0 and state is STABLE. A glitch back to the old level during PENDING therefore restarts qualification from zero.
  - If `s2[i]` != `sw_out[i]` and `cnt[i]` < STABLE_CYCLES-1: `cnt[i]` ← `cnt[i]`+1.
  - If `s2[i]` != `sw_out[i]` and `cnt[i]` == STABLE_CYCLES-1: `sw_out[i]` ← `s2[i]`, `cnt[i]` ← 0, and the matching `sw_rise[i]` or `sw_fall[i]` ← 1.
- Pulses:
  - `sw_rise`, `sw_fall` and `changed` are registered.
  - They are high for exactly one cycle, then return to 0 unless another bit qualifies on that edge.
- Counter width rule:
  - `cnt` never exceeds STABLE_CYCLES-1, so no wrap is possible.
  - The compare is done at full derived width.
- Simultaneous events:
  - Multiple bits may qualify on the same edge. Each sets its own pulse bit, and `changed` is a single 1.
- Reset behaviour:
  - `s1`, `s2`, `cnt`, `sw_out`, `sw_rise`, `sw_fall` and `changed` all reset to 0.
  - Assertion mid-PENDING discards the partial count.
  - A switch held high through reset release qualifies normally afterward and produces a `sw_rise` pulse.

## Timing
- Reset values: all outputs are 0 while `rst` is high and on the first cycle after release.
- Latency, when `sw_in[i]` changes before edge k and is then held:
  - `s1` updates at edge k.
  - `s2` updates at edge k+1.
  - `sw_out[i]` and its pulse update at edge k+1+STABLE_CYCLES.
- STABLE_CYCLES = 1 gives a pure 2-flop synchronizer plus 1 register, for a total of 3 edges.
- Rejection: a level must be seen on `s2` for STABLE_CYCLES consecutive edges. A return to the old level for a single cycle resets the count.
- Throughput: there is no handshake; `sw_out` is level-valid every cycle.
- Downstream logic may sample `sw_out` directly.
- `rst` deassertion should be synchronized externally. The block only requires asynchronous assertion.

## Test plan
All scenarios use STABLE_CYCLES = 4 and WIDTH = 4.
- **Reset values:** hold `rst`=1 with `sw_in`=4'hF. All outputs must be 0. Release `rst`; `sw_out` must become 4'hF exactly 5 edges later, with `sw_rise`=4'hF and `changed`=1 for one cycle.
- **Clean edge:** `sw_in[0]` 0→1 before edge k. `sw_out[0]` must rise at edge k+5, `sw_rise[0]` must pulse for exactly one cycle, and `sw_fall` must stay 0.
- **Bounce:** toggle `sw_in[1]` 1,0,1,0,1 with a 2-cycle period, then hold at 1. `sw_out[1]` must stay 0 during the bounce and rise exactly 5 edges after the final 0→1.
- **Glitch rejection:** drive `sw_in[2]` high for 3 cycles, then back to 0. `sw_out[2]`, `sw_rise[2]` and `changed` must never assert.
- **Simultaneous bits:** `sw_in` 4'h0→4'h5 on the same cycle. Both bits must update together to `sw_out`=4'h5, with `sw_rise`=4'h5 and `changed`=1 for one cycle. Then drive 4'h5→4'h0; this must give `sw_fall`=4'h5.
- **Reset mid-PENDING:** pulse `rst` 2 edges into the qualification of `sw_in[3]`=1. `sw_out[3]` must be 0 through reset and then rise 5 edges after release.

Source files
------------

// File: rtl/sw_debounce_if.sv
// Switch-side bundle for sw_debounce: raw pad levels in, debounced levels and edge pulses out.
interface sw_debounce_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             changed;

  modport master (
    output sw_in,
    input  sw_out,
    input  sw_rise,
    input  sw_fall,
    input  changed
  );

  modport slave (
    input  sw_in,
    output sw_out,
    output sw_rise,
    output sw_fall,
    output changed
  );
endinterface

// File: rtl/sw_debounce.sv
// Per-bit two-flop synchronizer plus counting debouncer for the slide switches,
// producing clean levels and registered one-cycle rise/fall pulses.
module sw_debounce #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 1000000
) (
  input logic           clk,
  input logic           rst,
  sw_debounce_if.slave  sw
);

  localparam int            CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    STABLE,
    PENDING
  } state_t;

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] swOut_q;
  logic [WIDTH-1:0] swRise_q;
  logic [WIDTH-1:0] swFall_q;
  logic             changed_q;
  logic [CW-1:0]    cnt_q [WIDTH];
  state_t           state_q [WIDTH];

  logic [WIDTH-1:0] differ_d;
  logic [WIDTH-1:0] atLast_d;
  logic [WIDTH-1:0] qualify_d;
  logic [WIDTH-1:0] swRise_d;
  logic [WIDTH-1:0] swFall_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sw.sw_in;
      s2_q <= s1_q;
    end
  end

  // A bit qualifies when the synchronized level still differs on the edge its count reaches LAST.
  always_comb begin
    atLast_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      atLast_d[i] = (cnt_q[i] == LAST);
    end
    differ_d  = s2_q ^ swOut_q;
    qualify_d = differ_d & atLast_d;
    swRise_d  = qualify_d & s2_q;
    swFall_d  = qualify_d & ~s2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
      swOut_q   <= '0;
      swRise_q  <= '0;
      swFall_q  <= '0;
      changed_q <= 1'b0;
    end else begin
      swRise_q  <= swRise_d;
      swFall_q  <= swFall_d;
      changed_q <= |(swRise_d | swFall_d);
      for (int i = 0; i < WIDTH; i++) begin
        unique case (state_q[i])
          STABLE: begin
            if (!differ_d[i]) begin
              cnt_q[i] <= '0;
            end else if (qualify_d[i]) begin
              swOut_q[i] <= s2_q[i];
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i]   <= cnt_q[i] + CW'(1);
              state_q[i] <= PENDING;
            end
          end
          PENDING: begin
            // Any return to the accepted level throws away the partial count.
            if (!differ_d[i]) begin
              cnt_q[i]   <= '0;
              state_q[i] <= STABLE;
            end else if (qualify_d[i]) begin
              swOut_q[i] <= s2_q[i];
              cnt_q[i]   <= '0;
              state_q[i] <= STABLE;
            end else begin
              cnt_q[i] <= cnt_q[i] + CW'(1);
            end
          end
        endcase
      end
    end
  end

  assign sw.sw_out  = swOut_q;
  assign sw.sw_rise = swRise_q;
  assign sw.sw_fall = swFall_q;
  assign sw.changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with WIDTH=4, STABLE_CYCLES=4; input held before edge k lands on sw_out at edge k+5.
module tb_sw_debounce;

  logic clk;
  logic rst;
  int   nAsserts;
  int   nFail;

  sw_debounce_if #(.WIDTH(4)) swIf ();

  sw_debounce #(
    .WIDTH        (4),
    .STABLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw (swIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] value);
    swIf.sw_in = value;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] expOut, input logic [3:0] expRise,
                          input logic [3:0] expFall, input logic expChanged);
    checkOutput({tag, ".sw_out"},  32'(swIf.sw_out),  32'(expOut));
    checkOutput({tag, ".sw_rise"}, 32'(swIf.sw_rise), 32'(expRise));
    checkOutput({tag, ".sw_fall"}, 32'(swIf.sw_fall), 32'(expFall));
    checkOutput({tag, ".changed"}, 32'(swIf.changed), 32'(expChanged));
  endtask

  initial begin
    nAsserts = 0;
    nFail    = 0;
    $display("[TB] sw_debounce directed test start");

    rst = 1'b1;
    applyStimulus(4'hF);
    step(3);
    checkAll("reset_held", 4'h0, 4'h0, 4'h0, 1'b0);
    rst = 1'b0;
    step(1);
    checkAll("reset_first_cycle", 4'h0, 4'h0, 4'h0, 1'b0);
    step(4);
    checkAll("reset_edge5", 4'h0, 4'h0, 4'h0, 1'b0);
    step(1);
    checkAll("reset_rise", 4'hF, 4'hF, 4'h0, 1'b1);
    step(1);
    checkAll("reset_settled", 4'hF, 4'h0, 4'h0, 1'b0);

    applyStimulus(4'h0);
    step(5);
    checkAll("allfall_edge5", 4'hF, 4'h0, 4'h0, 1'b0);
    step(1);
    checkAll("allfall_pulse", 4'h0, 4'h0, 4'hF, 1'b1);
    step(1);
    checkAll("allfall_settled", 4'h0, 4'h0, 4'h0, 1'b0);

    applyStimulus(4'h1);
    step(5);
    checkAll("clean_edge5", 4'h0, 4'h0, 4'h0, 1'b0);
    step(1);
    checkAll("clean_rise", 4'h1, 4'h1, 4'h0, 1'b1);
    step(1);
    checkAll("clean_settled", 4'h1, 4'h0, 4'h0, 1'b0);

    for (int j = 0; j < 4; j++) begin
      applyStimulus((j % 2 == 0) ? 4'h3 : 4'h1);
      step(1);
      checkAll("bounce_hold", 4'h1, 4'h0, 4'h0, 1'b0);
    end
    applyStimulus(4'h3);
    for (int j = 0; j < 5; j++) begin
      step(1);
      checkAll("bounce_qualify", 4'h1, 4'h0, 4'h0, 1'b0);
    end
    step(1);
    checkAll("bounce_rise", 4'h3, 4'h2, 4'h0, 1'b1);
    step(1);
    checkAll("bounce_settled", 4'h3, 4'h0, 4'h0, 1'b0);

    applyStimulus(4'h7);
    step(3);
    checkAll("glitch_high", 4'h3, 4'h0, 4'h0, 1'b0);
    applyStimulus(4'h3);
    for (int j = 0; j < 7; j++) begin
      step(1);
      checkAll("glitch_reject", 4'h3, 4'h0, 4'h0, 1'b0);
    end

    applyStimulus(4'h0);
    step(6);
    checkAll("pre_sim_fall", 4'h0, 4'h0, 4'h3, 1'b1);
    step(1);
    applyStimulus(4'h5);
    step(5);
    checkAll("sim_edge5", 4'h0, 4'h0, 4'h0, 1'b0);
    step(1);
    checkAll("sim_rise", 4'h5, 4'h5, 4'h0, 1'b1);
    step(1);
    checkAll("sim_rise_settled", 4'h5, 4'h0, 4'h0, 1'b0);
    applyStimulus(4'h0);
    step(6);
    checkAll("sim_fall", 4'h0, 4'h0, 4'h5, 1'b1);
    step(1);
    checkAll("sim_fall_settled", 4'h0, 4'h0, 4'h0, 1'b0);

    applyStimulus(4'h8);
    step(4);
    checkAll("midpend_counting", 4'h0, 4'h0, 4'h0, 1'b0);
    rst = 1'b1;
    #1;
    checkAll("midpend_in_reset", 4'h0, 4'h0, 4'h0, 1'b0);
    step(2);
    checkAll("midpend_reset_held", 4'h0, 4'h0, 4'h0, 1'b0);
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step(1);
      checkAll("midpend_requalify", 4'h0, 4'h0, 4'h0, 1'b0);
    end
    step(1);
    checkAll("midpend_rise", 4'h8, 4'h8, 4'h0, 1'b1);
    step(1);
    checkAll("midpend_settled", 4'h8, 4'h0, 4'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
